// File: rtl/xbus_fifo.sv
// ============================================================================
// xbus_fifo
// ----------------------------------------------------------------------------
// Fixed-depth XBus word queue placed upstream of an MC9999 consumer. Words
// offered on the producer triplet (wr_x_*) are clamped to the XBus value
// range (-999..999) and stored. They are then re-offered in order on the
// consumer triplet (rd_x_*). Every flag and output is decoded from
// registered state only, so no *_in signal has a combinational path to any
// *_out signal.
//
// Optional feature (compile-time macro):
//   XBUS_FIFO_LEVEL_EN  defined   : level_out is a register. It is loaded
//                                   with the occupancy on each clk edge where
//                                   posedge_big_clk=1, and it holds between
//                                   ticks. The value captured is the
//                                   occupancy before that edge's push/pop.
//                       undefined : level_out is constant 0 and no level
//                                   register is built.
//
// Parameters:
//   DEPTH            number of stored words, legal range 2..64.
//
// Ports:
//   clk              system clock; all state changes on the rising edge.
//   rst_n            asynchronous active-low reset. It discards all words.
//   posedge_big_clk  one-clk pulse marking a time-unit boundary.
//   wr_x_in          producer data (11-bit two's complement).
//   wr_x_write_in    producer is offering wr_x_in.
//   wr_x_read_out    queue can accept a word this cycle (not full).
//   wr_x_out         tie-off, constant 0.
//   wr_x_write_out   tie-off, constant 0.
//   rd_x_out         head-of-queue word, 0 when empty.
//   rd_x_write_out   queue is offering rd_x_out (not empty).
//   rd_x_read_in     consumer is blocked reading this port.
//   rd_x_read_out    tie-off, constant 0.
//   level_out        sampled occupancy (see the optional feature above).
// ============================================================================
module xbus_fifo #(
  parameter int DEPTH = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        posedge_big_clk,
  input  logic [10:0] wr_x_in,
  input  logic        wr_x_write_in,
  output logic        wr_x_read_out,
  output logic [10:0] wr_x_out,
  output logic        wr_x_write_out,
  output logic [10:0] rd_x_out,
  output logic        rd_x_write_out,
  input  logic        rd_x_read_in,
  output logic        rd_x_read_out,
  output logic [10:0] level_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  localparam logic signed [10:0] XBUS_MAX = 11'sd999;
  localparam logic signed [10:0] XBUS_MIN = -11'sd999;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [10:0] mem [DEPTH];
  ptr_t        wp;
  ptr_t        rp;
  cnt_t        cnt;
  cnt_t        cnt_next;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [10:0] push_data;

  // Clamp a raw 11-bit word to the XBus value range.
  function automatic logic [10:0] xbus_sat(input logic signed [10:0] v);
    if (v > XBUS_MAX)      return XBUS_MAX;
    else if (v < XBUS_MIN) return XBUS_MIN;
    else                   return v;
  endfunction

  // Pointer increment with explicit wrap. DEPTH need not be a power of two,
  // so the wrap cannot rely on natural overflow.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake qualification
  // --------------------------------------------------------------------------
  // Both flags come from the registered count only. A pop in the same cycle
  // therefore never opens room for a push into a full queue, and a push into
  // an empty queue never falls through to the consumer in the same cycle.
  assign full      = (cnt == FULL_CNT);
  assign empty     = (cnt == '0);
  assign push      = wr_x_write_in && !full;
  assign pop       = rd_x_read_in && !empty;
  assign push_data = xbus_sat(wr_x_in);

  // --------------------------------------------------------------------------
  // Occupancy next-state
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_next and no
    // latch is inferred.
    cnt_next = cnt;
    unique case ({push, pop})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;  // idle, or push and pop together
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers and count
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then update together from pre-edge values, whatever the statement
      // order.
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= ptr_inc(wp);
      if (pop)  rp <= ptr_inc(rp);
      cnt <= cnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Storage array
  // --------------------------------------------------------------------------
  // NOTE: the array is deliberately not reset. Its contents are never
  // observed while cnt == 0, and leaving the reset off lets it map onto
  // plain registers or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_data;
  end

  // --------------------------------------------------------------------------
  // Consumer side
  // --------------------------------------------------------------------------
  assign rd_x_write_out = !empty;
  assign rd_x_out       = empty ? '0 : mem[rp];

  // --------------------------------------------------------------------------
  // Producer side
  // --------------------------------------------------------------------------
  assign wr_x_read_out  = !full;

  // --------------------------------------------------------------------------
  // Unused directions of the MC9999 port pair
  // --------------------------------------------------------------------------
  assign wr_x_out       = '0;
  assign wr_x_write_out = 1'b0;
  assign rd_x_read_out  = 1'b0;

  // --------------------------------------------------------------------------
  // Occupancy reporting
  // --------------------------------------------------------------------------
`ifdef XBUS_FIFO_LEVEL_EN
  cnt_t level_q;

  // Sampled once per time unit, like a simple-I/O value. It captures the
  // count before this edge's push/pop because cnt is read, not cnt_next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               level_q <= '0;
    else if (posedge_big_clk) level_q <= cnt;
  end

  assign level_out = 11'(level_q);
`else
  // The time-unit strobe only drives the level register. Without that
  // register the strobe is kept as a named sink.
  logic unused_big_clk;
  assign unused_big_clk = posedge_big_clk;
  assign level_out      = '0;
`endif

endmodule

// File: tb/tb_xbus_fifo.sv
// ============================================================================
// tb_xbus_fifo
// ----------------------------------------------------------------------------
// Self-checking bench for xbus_fifo with DEPTH=14. A table of single-cycle
// vectors covers ordering, simultaneous push/pop and saturation. Hand-written
// sequences cover wrap-around, full, mid-operation reset and level sampling.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// after the rising edge.
// ============================================================================
module tb_xbus_fifo;

  localparam int DEPTH = 14;

  logic        clk;
  logic        rst_n;
  logic        posedge_big_clk;
  logic [10:0] wr_x_in;
  logic        wr_x_write_in;
  logic        wr_x_read_out;
  logic [10:0] wr_x_out;
  logic        wr_x_write_out;
  logic [10:0] rd_x_out;
  logic        rd_x_write_out;
  logic        rd_x_read_in;
  logic        rd_x_read_out;
  logic [10:0] level_out;

  int passed = 0;
  int total  = 0;

  xbus_fifo #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .posedge_big_clk (posedge_big_clk),
    .wr_x_in         (wr_x_in),
    .wr_x_write_in   (wr_x_write_in),
    .wr_x_read_out   (wr_x_read_out),
    .wr_x_out        (wr_x_out),
    .wr_x_write_out  (wr_x_write_out),
    .rd_x_out        (rd_x_out),
    .rd_x_write_out  (rd_x_write_out),
    .rd_x_read_in    (rd_x_read_in),
    .rd_x_read_out   (rd_x_read_out),
    .level_out       (level_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each vector holds the inputs for one cycle and the outputs expected
  // after that cycle's rising edge.
  typedef struct {
    string       name;
    logic        wr;
    logic [10:0] din;
    logic        rd;
    logic        exp_valid;
    logic [10:0] exp_dout;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];

  // Reference queue for the wrap and full sequences.
  logic [10:0] model[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // One clock cycle with the given inputs.
  task automatic step(input logic wr, input logic [10:0] din, input logic rd, input logic tick);
    @(negedge clk);
    wr_x_write_in   = wr;
    wr_x_in         = din;
    rd_x_read_in    = rd;
    posedge_big_clk = tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_x_write_in   = 1'b0;
    wr_x_in         = '0;
    rd_x_read_in    = 1'b0;
    posedge_big_clk = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Clamp to the XBus range, computed on signed integers.
  function automatic logic [10:0] ref_sat(input int v);
    if (v > 999)  return 11'(999);
    if (v < -999) return 11'(-999);
    return 11'(v);
  endfunction

  // Advance the reference queue by one cycle: the pop decision and the full
  // check both use the pre-edge occupancy.
  task automatic model_step(input logic wr, input int v, input logic rd);
    int n;
    n = model.size();
    if (rd && n > 0) void'(model.pop_front());
    if (wr && n < DEPTH) model.push_back(ref_sat(v));
  endtask

  task automatic check_against_model(input string name);
    logic [10:0] exp_head;
    exp_head = (model.size() > 0) ? model[0] : 11'd0;
    check({name, " valid"}, 32'(rd_x_write_out), 32'(model.size() > 0));
    check({name, " dout"},  32'(rd_x_out),       32'(exp_head));
    check({name, " ready"}, 32'(wr_x_read_out),  32'(model.size() < DEPTH));
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // ---------------- reset values ----------------
    #2;
    check("reset valid",          32'(rd_x_write_out), 32'd0);
    check("reset ready",          32'(wr_x_read_out),  32'd1);
    check("reset dout",           32'(rd_x_out),       32'd0);
    check("reset level",          32'(level_out),      32'd0);
    check("reset wr_x_out",       32'(wr_x_out),       32'd0);
    check("reset wr_x_write_out", 32'(wr_x_write_out), 32'd0);
    check("reset rd_x_read_out",  32'(rd_x_read_out),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    // Ordering: 5, -7 (0x7F9), 999 (0x3E7).
    vecs.push_back('{"ord push 5",     1'b1, 11'd5,     1'b0, 1'b1, 11'd5,     1'b1});
    vecs.push_back('{"ord push -7",    1'b1, 11'h7F9,   1'b0, 1'b1, 11'd5,     1'b1});
    vecs.push_back('{"ord push 999",   1'b1, 11'h3E7,   1'b0, 1'b1, 11'd5,     1'b1});
    vecs.push_back('{"ord pop 5",      1'b0, 11'd0,     1'b1, 1'b1, 11'h7F9,   1'b1});
    vecs.push_back('{"ord pop -7",     1'b0, 11'd0,     1'b1, 1'b1, 11'h3E7,   1'b1});
    vecs.push_back('{"ord pop 999",    1'b0, 11'd0,     1'b1, 1'b0, 11'd0,     1'b1});
    vecs.push_back('{"ord empty read", 1'b0, 11'd0,     1'b1, 1'b0, 11'd0,     1'b1});
    // Simultaneous push/pop with three words queued.
    vecs.push_back('{"sim push 10",    1'b1, 11'd10,    1'b0, 1'b1, 11'd10,    1'b1});
    vecs.push_back('{"sim push 20",    1'b1, 11'd20,    1'b0, 1'b1, 11'd10,    1'b1});
    vecs.push_back('{"sim push 30",    1'b1, 11'd30,    1'b0, 1'b1, 11'd10,    1'b1});
    vecs.push_back('{"sim push42+pop", 1'b1, 11'd42,    1'b1, 1'b1, 11'd20,    1'b1});
    vecs.push_back('{"sim pop 20",     1'b0, 11'd0,     1'b1, 1'b1, 11'd30,    1'b1});
    vecs.push_back('{"sim pop 30",     1'b0, 11'd0,     1'b1, 1'b1, 11'd42,    1'b1});
    vecs.push_back('{"sim pop 42",     1'b0, 11'd0,     1'b1, 1'b0, 11'd0,     1'b1});
    // A producer that withdraws without being accepted leaves no trace.
    vecs.push_back('{"no-offer idle",  1'b0, 11'd55,    1'b0, 1'b0, 11'd0,     1'b1});
    // Saturation: 1023 stored as 999, -1024 (0x400) stored as -999 (0x419).
    vecs.push_back('{"sat push 1023",  1'b1, 11'h3FF,   1'b0, 1'b1, 11'h3E7,   1'b1});
    vecs.push_back('{"sat push -1024", 1'b1, 11'h400,   1'b0, 1'b1, 11'h3E7,   1'b1});

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].din, vecs[i].rd, 1'b0);
      check({vecs[i].name, " valid"}, 32'(rd_x_write_out), 32'(vecs[i].exp_valid));
      check({vecs[i].name, " dout"},  32'(rd_x_out),       32'(vecs[i].exp_dout));
      check({vecs[i].name, " ready"}, 32'(wr_x_read_out),  32'(vecs[i].exp_ready));
    end

    // ---------------- wrap: 20 more words interleaved with pops ----------------
    // The queue holds {999, -999} with wp=rp+2 at index 9. Twenty push+pop
    // cycles carry both pointers past index 13.
    model.delete();
    model.push_back(11'(999));
    model.push_back(11'(-999));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 11'(100 + i), 1'b1, 1'b0);
      model_step(1'b1, 100 + i, 1'b1);
      check_against_model($sformatf("wrap %0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 11'd0, 1'b1, 1'b0);
      model_step(1'b0, 0, 1'b1);
      check_against_model($sformatf("wrap drain %0d", i));
    end

    // ---------------- full ----------------
    do_reset();
    model.delete();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 11'(i), 1'b0, 1'b0);
      model_step(1'b1, i, 1'b0);
    end
    check("full ready",     32'(wr_x_read_out),  32'd0);
    check("full head",      32'(rd_x_out),       32'd1);
    // Offer 77 while full and not reading: it is refused.
    step(1'b1, 11'd77, 1'b0, 1'b0);
    check("full hold ready", 32'(wr_x_read_out), 32'd0);
    check("full hold head",  32'(rd_x_out),      32'd1);
    // Offer 77 together with a pop: the pop does not open room for it.
    step(1'b1, 11'd77, 1'b1, 1'b0);
    model_step(1'b1, 77, 1'b1);
    check("full pop ready", 32'(wr_x_read_out),  32'd1);
    check("full pop head",  32'(rd_x_out),       32'd2);
    // Retried offer is accepted next cycle.
    step(1'b1, 11'd77, 1'b0, 1'b0);
    model_step(1'b1, 77, 1'b0);
    check("full retry ready", 32'(wr_x_read_out), 32'd0);
    for (int i = 0; i <= DEPTH; i++) begin
      check_against_model($sformatf("full drain %0d", i));
      step(1'b0, 11'd0, 1'b1, 1'b0);
      model_step(1'b0, 0, 1'b1);
    end
    check("full drained valid", 32'(rd_x_write_out), 32'd0);

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 6; i++) step(1'b1, 11'(200 + i), 1'b0, 1'b0);
    check("mid-rst prequeued", 32'(rd_x_out), 32'd200);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("mid-rst valid", 32'(rd_x_write_out), 32'd0);
    check("mid-rst ready", 32'(wr_x_read_out),  32'd1);
    check("mid-rst dout",  32'(rd_x_out),       32'd0);
    #1 rst_n = 1'b1;
    step(1'b1, 11'd3, 1'b0, 1'b0);
    check("post-rst dout",  32'(rd_x_out),       32'd3);
    step(1'b0, 11'd0, 1'b1, 1'b0);
    check("post-rst empty", 32'(rd_x_write_out), 32'd0);

    // ---------------- level sampling ----------------
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 11'(10 + i), 1'b0, 1'b0);
`ifdef XBUS_FIFO_LEVEL_EN
    check("level before tick", 32'(level_out), 32'd0);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    check("level tick 4",      32'(level_out), 32'd4);
    step(1'b0, 11'd0, 1'b1, 1'b0);
    check("level hold pop1",   32'(level_out), 32'd4);
    step(1'b0, 11'd0, 1'b1, 1'b0);
    check("level hold pop2",   32'(level_out), 32'd4);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    check("level tick 2",      32'(level_out), 32'd2);
    // A tick coinciding with a pop captures the pre-pop count.
    step(1'b0, 11'd0, 1'b1, 1'b1);
    check("level tick+pop",    32'(level_out), 32'd2);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    check("level tick 1",      32'(level_out), 32'd1);
`else
    step(1'b0, 11'd0, 1'b0, 1'b1);
    check("level off tick",    32'(level_out), 32'd0);
    step(1'b0, 11'd0, 1'b1, 1'b0);
    step(1'b0, 11'd0, 1'b1, 1'b1);
    check("level off tick2",   32'(level_out), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/xbus_fifo.md
# xbus_fifo

Fixed-depth XBus queue that sits upstream of an MC9999 consumer. It stores 11-bit XBus words from a producer port and re-offers them in order on a consumer port. It plugs directly into an MC9999 x0/x1 port pair using the same data/write/read wire triplets. It decouples a bursty producer (another MC9999 or a sensor front end) from the consumer controller.

## Interface
- DEPTH, 14, number of stored words; legal range 2..64.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- posedge_big_clk  input  1  one-clk pulse marking a time-unit boundary; used only by the level feature.
- wr_x_in  input  11  producer data, two's complement.
- wr_x_write_in  input  1  producer is offering wr_x_in.
- wr_x_read_out  output  1  block will accept a word this cycle (not full).
- wr_x_out  output  11  tie-off, constant 0.
- wr_x_write_out  output  1  tie-off, constant 0.
- rd_x_out  output  11  head-of-queue word.
- rd_x_write_out  output  1  block is offering rd_x_out (not empty).
- rd_x_read_in  input  1  consumer is blocked reading this port.
- rd_x_read_out  output  1  tie-off, constant 0.
- level_out  output  11  queue occupancy (see Configuration).

## Operation
- Storage: DEPTH x 11-bit register array, write pointer wp, read pointer rp, occupancy count cnt (0..DEPTH).
- Push: on a clk edge where wr_x_write_in && wr_x_read_out, store sat(wr_x_in) at wp, then wp advances.
- Saturation: inputs above 999 are stored as 999, and inputs below -999 are stored as -999. This matches the XBus value range.
- Pop: on a clk edge where rd_x_write_out && rd_x_read_in, rp advances. The word has been delivered.
- Pointer wrap: DEPTH-1 -> 0. DEPTH need not be a power of two.
- Simultaneous push and pop in one cycle: both occur and cnt is unchanged.
- Full (cnt == DEPTH): wr_x_read_out is 0 and no push occurs. A pop in the same cycle does not enable a push; the producer retries next cycle.
- Empty (cnt == 0): rd_x_write_out is 0 and rd_x_out is 0. A push into an empty queue does not fall through in the same cycle.
- rd_x_out is mem[rp] while cnt > 0. It is stable until the pop edge.
- Producer deassertion without acceptance has no effect; no partial state is kept.
- Reset: cnt=0, wp=0, rp=0, level register 0. Array contents are don't-care.
- Reset asserted mid-transfer discards all queued words immediately.

## Timing
- Flags are derived combinationally from the registered cnt only. There is no combinational path from any *_in signal to any *_out signal.
- Write-to-visible latency: a word pushed at edge N appears on rd_x_out with rd_x_write_out=1 after edge N.
- Throughput: one push and one pop per clk.
- Output reset values:
  - wr_x_read_out = 1 (empty, so the queue can accept).
  - rd_x_write_out = 0.
  - rd_x_out = 0.
  - level_out = 0.
  - All tie-offs = 0.
- Outputs take these values asynchronously on rst_n falling. The first push can occur on the first clk edge after rst_n rises.

## Configuration
- XBUS_FIFO_LEVEL_EN defined: level_out is a register loaded with cnt on each clk edge where posedge_big_clk=1. It holds between ticks, like a simple-I/O value updated once per time unit. The sampled value is cnt before that edge's push/pop.
- XBUS_FIFO_LEVEL_EN undefined: level_out is constant 0 and no level register is built. The queue behaves identically otherwise.

## Test plan
- Ordering: after reset, push 5, -7, 999 on consecutive cycles with rd_x_read_in=0, then hold rd_x_read_in=1. Required: rd_x_out reads 5, -7, 999 on consecutive cycles, then rd_x_write_out=0 and rd_x_out=0.
- Full (DEPTH=14): push 14 words (values 1..14) with no reads. Required: wr_x_read_out=0 after the 14th edge. A 15th offer of value 77 is held off until one pop, is then accepted, and the drain order is 2..14, 77.
- Simultaneous: with cnt=3, assert both push (value 42) and pop for one cycle. Required: cnt stays 3, the old head is removed, and 42 emerges last.
- Saturation and wrap: push 1023 and -1024, then 20 more words interleaved with pops so that wp and rp wrap past index 13. Required: the first two words read back as 999 and -999, and all 22 words appear in order.
- Reset mid-operation: with 6 words queued, pulse rst_n low between clk edges. Required: rd_x_write_out=0, wr_x_read_out=1 and rd_x_out=0 immediately. The next push of value 3 reads back as 3.
- Level (XBUS_FIFO_LEVEL_EN defined): push 4 words, then pulse posedge_big_clk. Required: level_out=4 after that edge, held through 2 further pops until the next tick shows 2. With the macro undefined, level_out stays 0.
